id_stage_p: RTL



---
 rtl/id_stage_p_if.sv | 54 +++++
 rtl/id_stage_p.sv | 126 ++++++++++++
 2 files changed

// File: rtl/id_stage_p_if.sv
// Decode/issue stage bus: IF/ID instruction fields, writeback port, ID/EX slot and
// status outputs.
interface id_stage_p_if #(
  parameter int unsigned DW   = 16,
  parameter int unsigned NREG = 8,
  parameter int unsigned AW   = $clog2(NREG)
);
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] dec_rs_sel;
  logic [AW-1:0] dec_rt_sel;
  logic          dec_rs_used;
  logic          dec_rt_used;
  logic          dec_wr_en;
  logic [AW-1:0] dec_wr_sel;
  logic [DW-1:0] dec_imm;
  logic          dec_br;
  logic [1:0]    dec_cond;
  logic          dec_jmp;
  logic          dec_jr;
  logic          dec_halt;
  logic [DW-1:0] pc_2;
  logic          wb_en;
  logic [AW-1:0] wb_sel;
  logic [DW-1:0] wb_data;
  logic          ex_valid;
  logic [DW-1:0] ex_rs_data;
  logic [DW-1:0] ex_rt_data;
  logic [DW-1:0] ex_imm;
  logic [DW-1:0] ex_pc_2;
  logic          ex_wr_en;
  logic [AW-1:0] ex_wr_sel;
  logic          ex_halt;
  logic          redirect;
  logic [DW-1:0] redirect_pc;
  logic          halted;
  logic          err;

  modport slave (
    input  in_valid, dec_rs_sel, dec_rt_sel, dec_rs_used, dec_rt_used, dec_wr_en,
           dec_wr_sel, dec_imm, dec_br, dec_cond, dec_jmp, dec_jr, dec_halt, pc_2,
           wb_en, wb_sel, wb_data,
    output in_ready, ex_valid, ex_rs_data, ex_rt_data, ex_imm, ex_pc_2, ex_wr_en,
           ex_wr_sel, ex_halt, redirect, redirect_pc, halted, err
  );

  modport master (
    output in_valid, dec_rs_sel, dec_rt_sel, dec_rs_used, dec_rt_used, dec_wr_en,
           dec_wr_sel, dec_imm, dec_br, dec_cond, dec_jmp, dec_jr, dec_halt, pc_2,
           wb_en, wb_sel, wb_data,
    input  in_ready, ex_valid, ex_rs_data, ex_rt_data, ex_imm, ex_pc_2, ex_wr_en,
           ex_wr_sel, ex_halt, redirect, redirect_pc, halted, err
  );
endinterface

// File: rtl/id_stage_p.sv
// Decode/issue stage: register file with write-through bypass, per-register writer
// scoreboard interlock, branch/jump resolution and a registered ID/EX slot.
module id_stage_p #(
  parameter int unsigned DW    = 16,
  parameter int unsigned NREG  = 8,
  parameter int unsigned AW    = $clog2(NREG),
  parameter int unsigned CNT_W = 2
) (
  input  logic         clk,
  input  logic         rst,
  id_stage_p_if.slave  io
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [DW-1:0]    rf_q  [NREG];
  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];

  logic [DW-1:0] rs_data, rt_data;
  logic          rs_byp, rt_byp, wr_byp;
  logic          rs_haz, rt_haz, wr_full;
  logic          stall, issue, cond_true, sb_err, sb_inc, sb_dec;

  logic          ex_valid_q, ex_wr_en_q, ex_halt_q, halted_q, err_q;
  logic [DW-1:0] ex_rs_q, ex_rt_q, ex_imm_q, ex_pc_2_q;
  logic [AW-1:0] ex_wr_sel_q;

  assign rs_byp  = io.wb_en && (io.wb_sel == io.dec_rs_sel);
  assign rt_byp  = io.wb_en && (io.wb_sel == io.dec_rt_sel);
  assign wr_byp  = io.wb_en && (io.wb_sel == io.dec_wr_sel);
  assign rs_data = rs_byp ? io.wb_data : rf_q[io.dec_rs_sel];
  assign rt_data = rt_byp ? io.wb_data : rf_q[io.dec_rt_sel];

  // A single outstanding writer is cleared by a same-cycle writeback via the bypass.
  assign rs_haz = io.dec_rs_used && ((cnt_q[io.dec_rs_sel] > CNT_W'(1)) ||
                  ((cnt_q[io.dec_rs_sel] == CNT_W'(1)) && !rs_byp));
  assign rt_haz = io.dec_rt_used && ((cnt_q[io.dec_rt_sel] > CNT_W'(1)) ||
                  ((cnt_q[io.dec_rt_sel] == CNT_W'(1)) && !rt_byp));
  assign wr_full = io.dec_wr_en && (cnt_q[io.dec_wr_sel] == CntMax) && !wr_byp;

  assign stall       = rs_haz || rt_haz || wr_full || halted_q;
  assign issue       = io.in_valid && !stall;
  assign io.in_ready = issue;

  always_comb begin
    cond_true = 1'b0;
    unique case (io.dec_cond)
      2'b00:   cond_true = (rs_data == '0);
      2'b01:   cond_true = (rs_data != '0);
      2'b10:   cond_true = rs_data[DW-1];
      default: cond_true = !rs_data[DW-1];
    endcase
  end

  assign io.redirect    = issue && ((io.dec_br && cond_true) || io.dec_jmp || io.dec_jr);
  assign io.redirect_pc = (io.dec_jr ? rs_data : io.pc_2) + io.dec_imm;

  always_comb begin
    sb_err = 1'b0;
    sb_inc = 1'b0;
    sb_dec = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      cnt_d[i] = cnt_q[i];
      sb_inc   = issue && io.dec_wr_en && (io.dec_wr_sel == AW'(i));
      sb_dec   = io.wb_en && (io.wb_sel == AW'(i));
      if (sb_dec && (cnt_q[i] == '0)) sb_err = 1'b1;
      if (sb_inc && !sb_dec) begin
        if (cnt_q[i] == CntMax) sb_err = 1'b1;
        else                    cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (sb_dec && !sb_inc && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (io.wb_en) begin
      rf_q[io.wb_sel] <= io.wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
      ex_valid_q  <= 1'b0;
      ex_wr_en_q  <= 1'b0;
      ex_halt_q   <= 1'b0;
      ex_wr_sel_q <= '0;
      ex_rs_q     <= '0;
      ex_rt_q     <= '0;
      ex_imm_q    <= '0;
      ex_pc_2_q   <= '0;
      halted_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) cnt_q[i] <= cnt_d[i];
      ex_valid_q <= issue;
      if (issue) begin
        ex_rs_q     <= rs_data;
        ex_rt_q     <= rt_data;
        ex_imm_q    <= io.dec_imm;
        ex_pc_2_q   <= io.pc_2;
        ex_wr_en_q  <= io.dec_wr_en;
        ex_wr_sel_q <= io.dec_wr_sel;
        ex_halt_q   <= io.dec_halt;
        if (io.dec_halt) halted_q <= 1'b1;
      end
      if (sb_err) err_q <= 1'b1;
    end
  end

  assign io.ex_valid   = ex_valid_q;
  assign io.ex_rs_data = ex_rs_q;
  assign io.ex_rt_data = ex_rt_q;
  assign io.ex_imm     = ex_imm_q;
  assign io.ex_pc_2    = ex_pc_2_q;
  assign io.ex_wr_en   = ex_wr_en_q;
  assign io.ex_wr_sel  = ex_wr_sel_q;
  assign io.ex_halt    = ex_halt_q;
  assign io.halted     = halted_q;
  assign io.err        = err_q;

endmodule
